s27_array: RTL and testbench
============================

# s27_array

Parametrised multi-channel successor to the single-instance s27 sequential benchmark cell. `CH` independent copies of the s27 next-state/output logic, each with three state flops. Adds:
- clock-enable hold,
- a full scan chain over all `3*CH` flops,
- an optional registered output stage,
- a MISR signature compactor over the `G17` outputs.

It sits in the benchmark suite as a scalable sequential workload for mapping and equivalence flows.

## Interface
- `CH`, 4: channel count, 1..`SIG_W`.
- `OUT_REG`, 0: 1 = `G17` registered (one extra cycle of latency); 0 = combinational.
- `SIG_W`, 16: MISR width, at least 2.
- `POLY`, 16'h002D: MISR feedback polynomial, `SIG_W` bits.

Ports (clock and reset first):
- `CK` in 1: clock; all flops rising-edge.
- `RN` in 1: reset. Asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `VDD` in 1: supply tie, functionally ignored.
- `G0`, `G1`, `G2`, `G3` in `CH` each: per-channel primary inputs; bit c belongs to channel c.
- `EN` in 1: state update enable.
- `SE` in 1: scan shift enable.
- `SI` in 1: scan in.
- `SO` out 1: scan out.
- `SIG_EN` in 1: MISR accumulate enable.
- `SIG_CLR` in 1: synchronous MISR clear.
- `G17` out `CH`: per-channel output.
- `SIG` out `SIG_W`: MISR contents.

## Operation
Per-channel state is `s5`, `s6`, `s7`. The combinational logic for channel c is:
- `n14 = ~G0`
- `n12 = ~(G1 | s7)`
- `n13 = ~(G2 | n12)`
- `n8 = n14 & s6`
- `n15 = n12 | n8`
- `n16 = G3 | n8`
- `n9 = ~(n16 & n15)`
- `n11 = ~(s5 | n9)`
- `n10 = ~(n14 | n11)`
- `g17 = ~n11`

State update per cycle, in priority order:
1. `SE=1`: scan shift. Chain index k = 3c+j, with j=0 for `s5`, 1 for `s6`, 2 for `s7`. Bit 0 <= `SI`; bit k <= bit k-1. `SO` = bit 3*CH-1, driven directly from the flop. `EN` is ignored during shift.
2. `SE=0`, `EN=1`: functional capture, `s5<=n10`, `s6<=n11`, `s7<=n13`.
3. Otherwise: hold.

Output path:
- `OUT_REG=0`: `G17` = `g17`.
- `OUT_REG=1`: `G17` register loads `g17` every cycle, independent of `EN` and `SE`.

MISR update, in priority order:
1. `SIG_CLR=1`: clear to 0.
2. `SIG_EN=1` and `SE=0`: `SIG <= ({SIG[SIG_W-2:0],1'b0} ^ (SIG[SIG_W-1] ? POLY : 0)) ^ zero-extended g17`. It always compacts the combinational `g17`, regardless of `OUT_REG`.
3. Otherwise: hold.

During scan shift the MISR holds.

## Timing
- Reset (`RN` low, asynchronous assert, synchronous-safe deassert assumed upstream) sets:
  - all state flops to 0,
  - the `G17` register to 0 when `OUT_REG=1`,
  - `SIG` to 0,
  - `SO` to 0.
- With `OUT_REG=0` after reset, `G17[c] = ~(G3[c] & ~G1[c])`.
- Latency: state is visible one cycle after capture. `G17` has 0 cycles of latency for `OUT_REG=0` and 1 cycle for `OUT_REG=1`. `SIG` reflects a given `g17` one cycle later.
- Scan: a full unload/load takes `3*CH` cycles with `SE=1`. The first bit shifted out is channel `CH-1` `s7`.
- Reset mid-shift or mid-accumulate: everything returns to reset values immediately; no partial state survives.
- `SE` and `EN` high together: shift wins.
- `SIG_CLR` and `SIG_EN` high together: clear wins.

## Test plan
1. **Reset and static zeros.** `CH=4`, `OUT_REG=0`, reset, all inputs 0, `EN=1`, 5 cycles -> `G17=4'hF` every cycle, state stays 0, `SO=0`, `SIG=0`.
2. **State dependence, channel 0.**
   - Cycle 1: `G0=1`, `G1=0`, `G2=0`, `G3=1`, `EN=1` -> `G17[0]=0`; next state `s5=0`, `s6=1`, `s7=0`.
   - Then `G0=G1=G2=G3=0` -> `G17[0]=0`. From reset state the same input gives 1.
3. **Enable hold.** Repeat scenario 2 with `EN=0` on the first cycle -> state stays 0; `G17[0]=1` on the all-zero input.
4. **Scan shift.** `CH=2`, `SE=1`, shift `SI` pattern 101100 (first bit first) for 6 cycles, then 6 more cycles with `SI=0` -> `SO` emits 101100 in order. `EN` toggling during the shift has no effect.
5. **MISR.** `CH=2`, `SIG_W=4`, `POLY=4'h3`, all inputs 0, `SIG_EN=1` -> `SIG` sequence 0011, 0101, 1001, 0010. `SIG_CLR=1` with `SIG_EN=1` -> 0000 next cycle.
6. **Registered output and async reset.** `OUT_REG=1`, `G3[0]` rises with `G1[0]=0` -> `G17[0]` falls one cycle later. Pulse `RN` low mid-cycle -> `G17`, `SIG` and state are 0 immediately.

Source files
------------

// File: rtl/s27_array.sv
// s27_array: CH independent s27 sequential cells with a shared scan chain,
// clock-enable hold, optional registered G17 stage and a MISR over g17.
module s27_array #(
  parameter int unsigned      CH      = 4,
  parameter int unsigned      OUT_REG = 0,
  parameter int unsigned      SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h002D)
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             VDD,
  input  logic [CH-1:0]    G0,
  input  logic [CH-1:0]    G1,
  input  logic [CH-1:0]    G2,
  input  logic [CH-1:0]    G3,
  input  logic             EN,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  input  logic             SIG_EN,
  input  logic             SIG_CLR,
  output logic [CH-1:0]    G17,
  output logic [SIG_W-1:0] SIG
);

  localparam int unsigned NFF = 3 * CH;

  // Chain bit 3c+0 = s5, 3c+1 = s6, 3c+2 = s7 of channel c.
  logic [NFF-1:0]   chain_q;
  logic [NFF-1:0]   chain_d;
  logic [NFF-1:0]   cap_c;
  logic [CH-1:0]    g17_c;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  // Supply tie has no function in the logic model.
  logic unused_vdd;
  assign unused_vdd = VDD;

  // Per-channel s27 next-state and output logic.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic s5, s6, s7;
    logic n8, n9, n10, n11, n12, n13, n14, n15, n16;
    assign s5  = chain_q[3*c];
    assign s6  = chain_q[3*c+1];
    assign s7  = chain_q[3*c+2];
    assign n14 = ~G0[c];
    assign n12 = ~(G1[c] | s7);
    assign n13 = ~(G2[c] | n12);
    assign n8  = n14 & s6;
    assign n15 = n12 | n8;
    assign n16 = G3[c] | n8;
    assign n9  = ~(n16 & n15);
    assign n11 = ~(s5 | n9);
    assign n10 = ~(n14 | n11);
    assign g17_c[c]     = ~n11;
    assign cap_c[3*c]   = n10;
    assign cap_c[3*c+1] = n11;
    assign cap_c[3*c+2] = n13;
  end

  // State next value: shift beats capture beats hold.
  always_comb begin
    chain_d = chain_q;
    if (SE) begin
      chain_d = {chain_q[NFF-2:0], SI};
    end else if (EN) begin
      chain_d = cap_c;
    end
  end

  // MISR next value: clear beats accumulate; holds while shifting.
  always_comb begin
    sig_d = sig_q;
    if (SIG_CLR) begin
      sig_d = '0;
    end else if (SIG_EN && !SE) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ SIG_W'(g17_c);
    end
  end

  // State and signature registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      chain_q <= '0;
      sig_q   <= '0;
    end else begin
      chain_q <= chain_d;
      sig_q   <= sig_d;
    end
  end

  assign SO  = chain_q[NFF-1];
  assign SIG = sig_q;

  // Output stage: registered copy of g17, or straight through.
  if (OUT_REG != 0) begin : g_oreg
    logic [CH-1:0] g17_q;
    logic [CH-1:0] g17_d;

    // G17 register reloads every cycle, independent of EN/SE.
    always_comb begin
      g17_d = g17_c;
    end

    // Output register.
    always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
        g17_q <= '0;
      end else begin
        g17_q <= g17_d;
      end
    end

    assign G17 = g17_q;
  end else begin : g_ocomb
    assign G17 = g17_c;
  end

endmodule

// File: tb/tb_s27_array.sv
// Directed bench for s27_array: three instances cover the default build,
// a 2-channel/4-bit MISR build and a registered-output build.
module tb_s27_array;

  logic        CK;
  logic        RN;
  logic        VDD;
  logic [3:0]  G0, G1, G2, G3;
  logic        EN, SE, SI, SIG_EN, SIG_CLR;

  logic        so_a;
  logic [3:0]  g17_a;
  logic [15:0] sig_a;
  logic        so_b;
  logic [1:0]  g17_b;
  logic [3:0]  sig_b;
  logic        so_c;
  logic [1:0]  g17_o;
  logic [15:0] sig_c;

  int n_tests;
  int n_fail;

  s27_array #(.CH(4), .OUT_REG(0), .SIG_W(16), .POLY(16'h002D)) u_a (
    .CK(CK), .RN(RN), .VDD(VDD),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3),
    .EN(EN), .SE(SE), .SI(SI), .SO(so_a),
    .SIG_EN(SIG_EN), .SIG_CLR(SIG_CLR),
    .G17(g17_a), .SIG(sig_a)
  );

  s27_array #(.CH(2), .OUT_REG(0), .SIG_W(4), .POLY(4'h3)) u_b (
    .CK(CK), .RN(RN), .VDD(VDD),
    .G0(G0[1:0]), .G1(G1[1:0]), .G2(G2[1:0]), .G3(G3[1:0]),
    .EN(EN), .SE(SE), .SI(SI), .SO(so_b),
    .SIG_EN(SIG_EN), .SIG_CLR(SIG_CLR),
    .G17(g17_b), .SIG(sig_b)
  );

  s27_array #(.CH(2), .OUT_REG(1), .SIG_W(16), .POLY(16'h002D)) u_c (
    .CK(CK), .RN(RN), .VDD(VDD),
    .G0(G0[1:0]), .G1(G1[1:0]), .G2(G2[1:0]), .G3(G3[1:0]),
    .EN(EN), .SE(SE), .SI(SI), .SO(so_c),
    .SIG_EN(SIG_EN), .SIG_CLR(SIG_CLR),
    .G17(g17_o), .SIG(sig_c)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic clear_inputs();
    G0 = '0; G1 = '0; G2 = '0; G3 = '0;
    EN = 1'b0; SE = 1'b0; SI = 1'b0; SIG_EN = 1'b0; SIG_CLR = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CK);
    RN = 1'b0;
    @(negedge CK);
    @(negedge CK);
    RN = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    EN = 1'b1;
    @(negedge CK);
    RN = 1'b0;
    #1;
    n_tests++;
    if (g17_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_g17_reg got=%b exp=00", g17_o);
    end
    @(negedge CK);
    RN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (g17_a !== 4'hF) begin
        n_fail++;
        $display("FAIL zeros_g17 cyc=%0d got=%h exp=f", i, g17_a);
      end
      n_tests++;
      if (u_a.chain_q !== 12'h000) begin
        n_fail++;
        $display("FAIL zeros_state cyc=%0d got=%h exp=000", i, u_a.chain_q);
      end
      n_tests++;
      if (so_a !== 1'b0) begin
        n_fail++;
        $display("FAIL zeros_so cyc=%0d got=%b exp=0", i, so_a);
      end
      n_tests++;
      if (sig_a !== 16'h0000) begin
        n_fail++;
        $display("FAIL zeros_sig cyc=%0d got=%h exp=0000", i, sig_a);
      end
    end
  endtask

  task automatic test_state_dep();
    clear_inputs();
    apply_reset();
    EN = 1'b1;
    G0 = 4'b0001;
    G3 = 4'b0001;
    #1;
    n_tests++;
    if (g17_a !== 4'b1110) begin
      n_fail++;
      $display("FAIL dep_g17_first got=%b exp=1110", g17_a);
    end
    tick();
    n_tests++;
    if (u_a.chain_q !== 12'h002) begin
      n_fail++;
      $display("FAIL dep_state got=%h exp=002", u_a.chain_q);
    end
    G0 = '0;
    G3 = '0;
    #1;
    n_tests++;
    if (g17_a !== 4'b1110) begin
      n_fail++;
      $display("FAIL dep_g17_zero_in got=%b exp=1110", g17_a);
    end
    tick();
    n_tests++;
    if (u_a.chain_q !== 12'h002) begin
      n_fail++;
      $display("FAIL dep_state_hold got=%h exp=002", u_a.chain_q);
    end
  endtask

  task automatic test_enable_hold();
    clear_inputs();
    apply_reset();
    EN = 1'b0;
    G0 = 4'b0001;
    G3 = 4'b0001;
    tick();
    n_tests++;
    if (u_a.chain_q !== 12'h000) begin
      n_fail++;
      $display("FAIL hold_state got=%h exp=000", u_a.chain_q);
    end
    G0 = '0;
    G3 = '0;
    #1;
    n_tests++;
    if (g17_a !== 4'hF) begin
      n_fail++;
      $display("FAIL hold_g17 got=%b exp=1111", g17_a);
    end
  endtask

  task automatic test_scan();
    logic [5:0] pat;
    pat = 6'b101100;
    clear_inputs();
    apply_reset();
    SE = 1'b1;
    SIG_EN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      SI = (i < 6) ? pat[5-i] : 1'b0;
      EN = (i % 2 == 0);
      tick();
      if (i >= 5 && i <= 10) begin
        n_tests++;
        if (so_b !== pat[10-i]) begin
          n_fail++;
          $display("FAIL scan_so cyc=%0d got=%b exp=%b", i, so_b, pat[10-i]);
        end
      end
      if (i == 5) begin
        n_tests++;
        if (u_b.chain_q !== 6'b101100) begin
          n_fail++;
          $display("FAIL scan_load got=%b exp=101100", u_b.chain_q);
        end
      end
      n_tests++;
      if (sig_b !== 4'h0) begin
        n_fail++;
        $display("FAIL scan_sig_hold cyc=%0d got=%h exp=0", i, sig_b);
      end
    end
    clear_inputs();
  endtask

  task automatic test_misr();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0011;
    exp_seq[1] = 4'b0101;
    exp_seq[2] = 4'b1001;
    exp_seq[3] = 4'b0010;
    clear_inputs();
    apply_reset();
    SIG_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (sig_b !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL misr_seq step=%0d got=%b exp=%b", i, sig_b, exp_seq[i]);
      end
    end
    SIG_CLR = 1'b1;
    tick();
    n_tests++;
    if (sig_b !== 4'b0000) begin
      n_fail++;
      $display("FAIL misr_clr got=%b exp=0000", sig_b);
    end
    clear_inputs();
  endtask

  task automatic test_out_reg_async();
    clear_inputs();
    apply_reset();
    EN = 1'b1;
    SIG_EN = 1'b1;
    tick();
    n_tests++;
    if (g17_o !== 2'b11) begin
      n_fail++;
      $display("FAIL oreg_idle got=%b exp=11", g17_o);
    end
    G3 = 4'b0001;
    #1;
    n_tests++;
    if (g17_o !== 2'b11) begin
      n_fail++;
      $display("FAIL oreg_latency got=%b exp=11", g17_o);
    end
    tick();
    n_tests++;
    if (g17_o !== 2'b10) begin
      n_fail++;
      $display("FAIL oreg_fall got=%b exp=10", g17_o);
    end
    n_tests++;
    if (sig_c !== 16'h0004) begin
      n_fail++;
      $display("FAIL oreg_sig got=%h exp=0004", sig_c);
    end
    n_tests++;
    if (u_c.chain_q !== 6'h02) begin
      n_fail++;
      $display("FAIL oreg_state got=%h exp=02", u_c.chain_q);
    end
    #2;
    RN = 1'b0;
    #1;
    n_tests++;
    if (g17_o !== 2'b00) begin
      n_fail++;
      $display("FAIL async_g17 got=%b exp=00", g17_o);
    end
    n_tests++;
    if (sig_c !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_sig got=%h exp=0000", sig_c);
    end
    n_tests++;
    if (u_c.chain_q !== 6'h00) begin
      n_fail++;
      $display("FAIL async_state got=%h exp=00", u_c.chain_q);
    end
    @(negedge CK);
    RN = 1'b1;
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    VDD = 1'b1;
    RN  = 1'b0;
    clear_inputs();
    test_reset();
    test_state_dep();
    test_enable_hold();
    test_scan();
    test_misr();
    test_out_reg_async();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
